// File: rtl/isqrt_iter_if.sv
// Argument/result port bundle between the formula FSMs and the isqrt unit.
// x_vld is a one-cycle pulse taken only while the unit is idle (no ready signal);
// y_vld is a one-cycle result pulse with no backpressure; y holds until the next result.
interface isqrt_iter_if #(
  parameter int X_W = 32
);
  logic             x_vld;
  logic [X_W-1:0]   x;
  logic             y_vld;
  logic [X_W/2-1:0] y;
  logic             busy;

  modport master (output x_vld, x, input y_vld, y, busy);
  modport slave  (input x_vld, x, output y_vld, y, busy);
endinterface

// File: rtl/isqrt_iter.sv
// Sequential floor(sqrt(x)): one result bit per clock through a single
// restoring-subtract stage. Results arrive a fixed X_W/2+1 cycles after accept.
module isqrt_iter #(
  parameter int X_W = 32
) (
  input  logic clk,
  input  logic rst,
  isqrt_iter_if.slave io
);
  localparam int H  = X_W / 2;
  localparam int RW = H + 4;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [X_W-1:0] sreg;
  logic [RW-1:0]  rem, rem_sh, rem_nxt, trial;
  logic [H-1:0]   root, root_nxt, y_q;
  logic [CW-1:0]  cnt;
  logic           y_vld_q;
  logic           accept, done;

  always_comb begin
    state_nxt = state;
    accept    = (state == IDLE) && io.x_vld;
    done      = (state == RUN) && (cnt == '0);
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step: bring down the next bit pair, try subtracting 4*root+1.
  always_comb begin
    rem_sh   = {rem[RW-3:0], sreg[X_W-1 -: 2]};
    trial    = {{(RW-H-2){1'b0}}, root, 2'b01};
    rem_nxt  = rem_sh;
    root_nxt = {root[H-2:0], 1'b0};
    if (rem_sh >= trial) begin
      rem_nxt  = rem_sh - trial;
      root_nxt = {root[H-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      rem     <= '0;
      root    <= '0;
      cnt     <= '0;
      y_q     <= '0;
      y_vld_q <= 1'b0;
    end else begin
      y_vld_q <= 1'b0;
      if (accept) begin
        sreg <= io.x;
        rem  <= '0;
        root <= '0;
        cnt  <= CW'(H - 1);
      end else if (state == RUN) begin
        sreg <= {sreg[X_W-3:0], 2'b00};
        rem  <= rem_nxt;
        root <= root_nxt;
        if (done) begin
          y_q     <= root_nxt;
          y_vld_q <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign io.busy  = (state == RUN);
  assign io.y     = y_q;
  assign io.y_vld = y_vld_q;
endmodule

// File: doc/isqrt_iter.md
# isqrt_iter

Sequential integer square root unit computing y = floor(sqrt(x)) for a 32-bit unsigned x, one result bit per clock, using a single shared restoring-subtract datapath. It sits directly downstream of the formula FSMs (`formula_1_fsm`, `formula_2_fsm`) and is the one isqrt instance they drive through their `isqrt_x_vld/isqrt_x` and `isqrt_y_vld/isqrt_y` ports. It trades throughput for area: one operation in flight, fixed latency, no backpressure.

## Interface

- `X_W`, 32, radicand width; must be even. Result width is X_W/2.

- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `x_vld`  input  1  argument valid; single-cycle pulse from the FSM.
- `x`  input  X_W  unsigned radicand, sampled only when accepted.
- `y_vld`  output  1  result valid; one-cycle pulse.
- `y`  output  X_W/2  floor(sqrt(x)); holds its value until the next result.
- `busy`  output  1  high while an operation is in flight.

## Operation

- States: IDLE, RUN. `busy` = (state == RUN).
- Accept: `x_vld` high while in IDLE. On the accepting edge:
  - latch x into a shift register;
  - clear `rem` (X_W/2+4 bits) and `root` (X_W/2 bits);
  - load `cnt` = X_W/2−1;
  - go to RUN.
- Each RUN edge performs one iteration:
  - rem' = (rem << 2) | top two bits of shift reg; shift reg <<= 2;
  - trial = (root << 2) | 1, zero-extended to rem width;
  - if rem' ≥ trial: rem = rem' − trial, root = (root << 1) | 1;
  - else: rem = rem', root = root << 1.
- On the RUN edge where cnt == 0:
  - do the final iteration;
  - register `y` = final root and set `y_vld` = 1;
  - return to IDLE.
- Otherwise cnt decrements.
- `y_vld` is registered and cleared on every edge except the completing one.
- `y` is updated only on completion and is stable between results.
- `x_vld` while in RUN is ignored: no latch, no queueing, no error. Upstream FSMs never do this by construction; the bench checks that it is harmless.
- All arithmetic is unsigned. The full X_W range is valid. No overflow is possible with `rem` at X_W/2+4 bits.

## Timing

- Call the accept cycle cycle 0.
- `busy` is high in cycles 1 .. X_W/2 (1..16 at default).
- `y_vld` is high in cycle X_W/2+1 (cycle 17 at default), for exactly one cycle. `busy` is low in that cycle.
- Fixed latency: 17 cycles from accept to `y_vld`, independent of data.
- Back-to-back:
  - FSMs drive `x_vld` combinationally from `y_vld`, so `x_vld` high in the `y_vld` cycle must be accepted. The state is already IDLE then.
  - Throughput is one result per 17 cycles.
- Reset values: state IDLE, `busy` 0, `y_vld` 0, `y` 0, `cnt` 0.
- Reset mid-operation:
  - the operation is aborted and no `y_vld` is ever produced for it;
  - `y` is cleared to 0;
  - `x_vld` in the cycle `rst` is high is ignored.
- `x_vld` and `rst` are never assumed mutually exclusive; `rst` wins.

## Test plan

- x = 0 accepted in cycle 0 -> `y_vld` only in cycle 17, y = 0; `busy` high in cycles 1–16 only.
- x = 16, 15, 17 (separate runs) -> y = 4, 3, 4 respectively.
- x = 0xFFFF_FFFF -> y = 0xFFFF. x = 0xFFFE_0001 -> y = 0xFFFF. x = 0xFFFE_0000 -> y = 0xFFFE.
- Chaining:
  - x = 9 -> y = 3 with `y_vld` in cycle 17;
  - `x_vld` asserted in that same cycle with x = 3 + 22 = 25 -> accepted;
  - y = 5 with `y_vld` in cycle 34;
  - `y` holds 3 during cycles 18–33.
- Busy drop: x = 100 accepted, then x = 49 pulsed in cycle 5 -> ignored; single `y_vld` in cycle 17 with y = 10.
- Reset mid-op:
  - x = 1000 accepted, `rst` high in cycle 8 -> `y_vld` stays 0 through cycle 40, y = 0, `busy` 0 from cycle 9;
  - a new x = 1024 after reset -> y = 32.
- Random: 10k random x with random idle gaps, including the `y_vld`-cycle accept -> every y matches the floor(sqrt(x)) model, and `y_vld` count equals accepted count.
